alu_control_dmem: RTL and testbench
===================================

# alu_control_dmem

Execute/memory slice of the rv32i single-cycle core. It combines three parts:
- the main control decoder (opcode/func3/func7 to datapath controls and branch decision);
- the 32-bit ALU;
- a 1 KiB word-organised data BRAM with a testbench init port and a debug read port.

It sits between the register file/sign-extender and the write-back mux. The branch output drives the PC select.

## Interface
- DATA_WIDTH, 32, datapath width.
- MEM_ADDR_WIDTH, 10, byte-address width of the data BRAM (256 words).
- clk  in  1  rising-edge clock for BRAM writes.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- opcode  in  7  instruction[6:0].
- func3  in  3  instruction[14:12].
- func7  in  7  instruction[31:25].
- rs1, rs2  in  32  register-file read data.
- sign_ext  in  32  extended immediate.
- init_done  in  1  0: BRAM write port driven by init_*; 1: driven by datapath.
- init_addr  in  10  init write byte address.
- init_dat  in  32  init write data.
- init_enb  in  1  init write enable.
- debug_addr  in  10  debug read byte address.
- branch  out  1  take branch/jump (PC select).
- imm_src  out  3  immediate format: I=000, S=001, B=010, U=011, J=100.
- mem_read, mem_2_reg, mem_write, alu_src, reg_write  out  1 each.
- alu_ctrl  out  4  ALU operation.
- wrt_back_src  out  2  ALU_RESULTS=00, MEMORY_READ=01, PC_PLUS_4=10.
- alu_results  out  32  ALU result (also the BRAM address).
- alu_zero  out  1  alu_results == 0.
- r_dat  out  32  data BRAM read data.
- debug_data  out  32  word at debug_addr.

## Operation
- ALU operand A is rs1. Operand B is alu_src ? sign_ext : rs2.
- alu_ctrl encodings:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR;
  - 0101 SLL, 0110 SRL, 0111 SRA (shift amount B[4:0]);
  - 1000 SLT (signed, result 1/0), 1001 SLTU, 1010 PASS_B;
  - any other encoding gives result 0.
- All arithmetic is mod 2^32 with no overflow flag.
- Decode, by opcode:
  - 0110011 (R-type):
    - reg_write=1, alu_src=0, wb=ALU;
    - func3 000 gives ADD, or SUB when func7[5]=1;
    - 001 SLL, 010 SLT, 011 SLTU, 100 XOR;
    - 101 SRL, or SRA when func7[5]=1;
    - 110 OR, 111 AND.
  - 0010011 (I-type ALU): imm I, alu_src=1, reg_write=1, wb=ALU. Same func3 map; SUB never selected; SRAI when func7[5]=1.
  - 0000011 (load): imm I, alu_src=1, ADD, mem_read=1, mem_2_reg=1, reg_write=1, wb=MEM. All func3 values are treated as lw.
  - 0100011 (store): imm S, alu_src=1, ADD, mem_write=1.
  - 1100011 (branch): imm B, alu_src=0.
    - beq: SUB, branch=zero. bne: SUB, branch=~zero.
    - blt: SLT, branch=~zero. bge: SLT, branch=zero.
    - bltu: SLTU, branch=~zero. bgeu: SLTU, branch=zero.
    - func3 010/011: branch=0.
  - 1101111 (jal): imm J, branch=1, reg_write=1, wb=PC_PLUS_4.
  - 0110111 (lui): imm U, alu_src=1, PASS_B, reg_write=1, wb=ALU.
  - Any other opcode: all control outputs 0.
- Every control output not set by the selected opcode is 0.
- BRAM organisation:
  - storage is 256×32;
  - word index = address[9:2], and address bits [1:0] are ignored;
  - the write port takes address, data and enable from init_* when init_done=0, and from alu_results[9:0], rs2 and mem_write when init_done=1.
- BRAM read:
  - r_dat = mem[alu_results[9:2]] when mem_read=1, else 0;
  - debug_data = mem[debug_addr[9:2]] always.
- Memory contents are not cleared by reset. Contents are undefined until written.

## Timing
- Control, ALU, r_dat and debug_data are purely combinational from their inputs.
- While rst=0:
  - all control outputs and r_dat are forced to 0;
  - alu_results still follows its inputs;
  - BRAM writes are blocked.
- Writes:
  - occur on the rising clk edge when the selected write enable is 1 and rst=1;
  - one word per cycle;
  - the new value is visible on r_dat/debug_data after that edge.
- A read of the address being written in the same cycle returns the old word until the edge.
- Asserting rst mid-write aborts that write; memory keeps its prior value.
- Toggling init_done takes effect combinationally; the switching cycle uses the new source.

## Test plan
- Init port, then debug read: with init_done=0, write 0x3, 0x3, 0x5 to addresses 0x0, 0x4, 0x8 → debug_data at 0x0/0x4/0x8 = 00000003/00000003/00000005; address 0x2 aliases word 0.
- lw: opcode 0000011, rs1=0, sign_ext=8, init_done=1 → alu_results=8, mem_read=1, wrt_back_src=01, r_dat=00000005.
- sw then debug: opcode 0100011, rs1=0, sign_ext=0xC, rs2=5, one clock → debug_data at 0xC = 00000005; with rst=0 during the edge, memory is unchanged.
- beq/bne: rs1=rs2=3 gives beq branch=1, bne branch=0. With rs1=3, rs2=5: beq branch=0, bne branch=1, imm_src=010.
- ALU: opcode 0110011 func7=0100000 func3=000 with 5,3 → result 2. SRA on 0x80000000 by 4 → 0xF8000000. SLTU on 0xFFFFFFFF, 1 → 0 and SLT → 1.
- Reset and jal: rst=0 → every control output 0 and r_dat=0. Opcode 1101111 → branch=1, imm_src=100, wrt_back_src=10, reg_write=1.

Source files
------------

// File: rtl/alu_control_dmem.sv
// Execute/memory slice of the rv32i single-cycle core: main control decoder,
// 32-bit ALU and a word-organised data BRAM with an init write port and a
// debug read port. Everything except the BRAM write is combinational.
module alu_control_dmem #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [6:0]                opcode,
  input  logic [2:0]                func3,
  input  logic [6:0]                func7,
  input  logic [DATA_WIDTH-1:0]     rs1,
  input  logic [DATA_WIDTH-1:0]     rs2,
  input  logic [DATA_WIDTH-1:0]     sign_ext,
  input  logic                      init_done,
  input  logic [MEM_ADDR_WIDTH-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0]     init_dat,
  input  logic                      init_enb,
  input  logic [MEM_ADDR_WIDTH-1:0] debug_addr,
  output logic                      branch,
  output logic [2:0]                imm_src,
  output logic                      mem_read,
  output logic                      mem_2_reg,
  output logic                      mem_write,
  output logic                      alu_src,
  output logic                      reg_write,
  output logic [3:0]                alu_ctrl,
  output logic [1:0]                wrt_back_src,
  output logic [DATA_WIDTH-1:0]     alu_results,
  output logic                      alu_zero,
  output logic [DATA_WIDTH-1:0]     r_dat,
  output logic [DATA_WIDTH-1:0]     debug_data
);

  localparam int IDX_W = MEM_ADDR_WIDTH - 2;
  localparam int WORDS = 2 ** IDX_W;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // How the ALU zero flag turns into a PC select.
  localparam logic [1:0] BR_NONE   = 2'd0;
  localparam logic [1:0] BR_ZERO   = 2'd1;
  localparam logic [1:0] BR_NZERO  = 2'd2;
  localparam logic [1:0] BR_ALWAYS = 2'd3;

  // Shared func3 map for register and immediate ALU ops; sub_ok keeps SUB
  // out of the immediate forms while still allowing SRAI.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt,
                                          input logic sub_ok);
    case (f3)
      3'b000:  return (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  logic [2:0]            imm_src_s;
  logic                  mem_read_s, mem_2_reg_s, mem_write_s, alu_src_s, reg_write_s;
  logic [3:0]            alu_ctrl_s;
  logic [1:0]            wb_src_s;
  logic [1:0]            br_kind_s;
  logic                  branch_s;
  logic [DATA_WIDTH-1:0] operand_b_s;
  logic [DATA_WIDTH-1:0] alu_res_s;
  logic [4:0]            shamt_s;
  logic                  wr_en_s;
  logic [IDX_W-1:0]      wr_idx_s;
  logic [DATA_WIDTH-1:0] wr_dat_s;
  logic [DATA_WIDTH-1:0] mem_r [WORDS];
  logic                  unused_bits_s;

  assign unused_bits_s = ^{func7[6], func7[4:0], init_addr[1:0], debug_addr[1:0]};

  // Main decoder: opcode/func3/func7 to raw (ungated) datapath controls.
  always_comb begin
    imm_src_s   = IMM_I;
    mem_read_s  = 1'b0;
    mem_2_reg_s = 1'b0;
    mem_write_s = 1'b0;
    alu_src_s   = 1'b0;
    reg_write_s = 1'b0;
    alu_ctrl_s  = ALU_ADD;
    wb_src_s    = WB_ALU;
    br_kind_s   = BR_NONE;
    case (opcode)
      OP_R: begin
        reg_write_s = 1'b1;
        alu_ctrl_s  = arith_op(func3, func7[5], 1'b1);
      end
      OP_I: begin
        alu_src_s   = 1'b1;
        reg_write_s = 1'b1;
        alu_ctrl_s  = arith_op(func3, func7[5], 1'b0);
      end
      OP_LOAD: begin
        alu_src_s   = 1'b1;
        mem_read_s  = 1'b1;
        mem_2_reg_s = 1'b1;
        reg_write_s = 1'b1;
        wb_src_s    = WB_MEM;
      end
      OP_STORE: begin
        imm_src_s   = IMM_S;
        alu_src_s   = 1'b1;
        mem_write_s = 1'b1;
      end
      OP_BRANCH: begin
        imm_src_s = IMM_B;
        case (func3)
          3'b000:  begin alu_ctrl_s = ALU_SUB;  br_kind_s = BR_ZERO;  end
          3'b001:  begin alu_ctrl_s = ALU_SUB;  br_kind_s = BR_NZERO; end
          3'b100:  begin alu_ctrl_s = ALU_SLT;  br_kind_s = BR_NZERO; end
          3'b101:  begin alu_ctrl_s = ALU_SLT;  br_kind_s = BR_ZERO;  end
          3'b110:  begin alu_ctrl_s = ALU_SLTU; br_kind_s = BR_NZERO; end
          3'b111:  begin alu_ctrl_s = ALU_SLTU; br_kind_s = BR_ZERO;  end
          default: begin alu_ctrl_s = ALU_ADD;  br_kind_s = BR_NONE;  end
        endcase
      end
      OP_JAL: begin
        imm_src_s   = IMM_J;
        reg_write_s = 1'b1;
        wb_src_s    = WB_PC4;
        br_kind_s   = BR_ALWAYS;
      end
      OP_LUI: begin
        imm_src_s   = IMM_U;
        alu_src_s   = 1'b1;
        reg_write_s = 1'b1;
        alu_ctrl_s  = ALU_PASS;
      end
      default: begin
        imm_src_s = IMM_I;
      end
    endcase
  end

  assign operand_b_s = alu_src_s ? sign_ext : rs2;
  assign shamt_s     = operand_b_s[4:0];

  // ALU: runs off the raw decode so alu_results keeps following inputs in reset.
  always_comb begin
    alu_res_s = {DATA_WIDTH{1'b0}};
    case (alu_ctrl_s)
      ALU_ADD:  alu_res_s = rs1 + operand_b_s;
      ALU_SUB:  alu_res_s = rs1 - operand_b_s;
      ALU_AND:  alu_res_s = rs1 & operand_b_s;
      ALU_OR:   alu_res_s = rs1 | operand_b_s;
      ALU_XOR:  alu_res_s = rs1 ^ operand_b_s;
      ALU_SLL:  alu_res_s = rs1 << shamt_s;
      ALU_SRL:  alu_res_s = rs1 >> shamt_s;
      ALU_SRA:  alu_res_s = $unsigned($signed(rs1) >>> shamt_s);
      ALU_SLT:  alu_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs1) < $signed(operand_b_s))};
      ALU_SLTU: alu_res_s = {{(DATA_WIDTH-1){1'b0}}, (rs1 < operand_b_s)};
      ALU_PASS: alu_res_s = operand_b_s;
      default:  alu_res_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  assign alu_results = alu_res_s;
  assign alu_zero    = (alu_res_s == {DATA_WIDTH{1'b0}});

  // Branch decision from the zero flag and the decoded branch kind.
  always_comb begin
    case (br_kind_s)
      BR_ZERO:   branch_s = alu_zero;
      BR_NZERO:  branch_s = ~alu_zero;
      BR_ALWAYS: branch_s = 1'b1;
      default:   branch_s = 1'b0;
    endcase
  end

  // Control outputs are held at zero while reset is asserted.
  always_comb begin
    if (!rst) begin
      branch       = 1'b0;
      imm_src      = 3'b000;
      mem_read     = 1'b0;
      mem_2_reg    = 1'b0;
      mem_write    = 1'b0;
      alu_src      = 1'b0;
      reg_write    = 1'b0;
      alu_ctrl     = 4'd0;
      wrt_back_src = 2'b00;
    end else begin
      branch       = branch_s;
      imm_src      = imm_src_s;
      mem_read     = mem_read_s;
      mem_2_reg    = mem_2_reg_s;
      mem_write    = mem_write_s;
      alu_src      = alu_src_s;
      reg_write    = reg_write_s;
      alu_ctrl     = alu_ctrl_s;
      wrt_back_src = wb_src_s;
    end
  end

  // Write-port source select: init port until init_done, datapath afterwards.
  always_comb begin
    if (init_done) begin
      wr_en_s  = mem_write;
      wr_idx_s = alu_res_s[MEM_ADDR_WIDTH-1:2];
      wr_dat_s = rs2;
    end else begin
      wr_en_s  = init_enb;
      wr_idx_s = init_addr[MEM_ADDR_WIDTH-1:2];
      wr_dat_s = init_dat;
    end
  end

  // BRAM write; contents are never cleared and writes are blocked in reset.
  always_ff @(posedge clk) begin
    if (rst && wr_en_s) begin
      mem_r[wr_idx_s] <= wr_dat_s;
    end
  end

  // Datapath read port, zero unless a load is decoded.
  always_comb begin
    if (mem_read) begin
      r_dat = mem_r[alu_res_s[MEM_ADDR_WIDTH-1:2]];
    end else begin
      r_dat = {DATA_WIDTH{1'b0}};
    end
  end

  assign debug_data = mem_r[debug_addr[MEM_ADDR_WIDTH-1:2]];

endmodule

// File: tb/tb_alu_control_dmem.sv
// Self-checking bench for alu_control_dmem: directed cases followed by
// randomized vectors compared against a behavioural model of the slice.
module tb_alu_control_dmem;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] rs1, rs2, sign_ext;
  logic        init_done;
  logic [9:0]  init_addr;
  logic [31:0] init_dat;
  logic        init_enb;
  logic [9:0]  debug_addr;
  logic        branch;
  logic [2:0]  imm_src;
  logic        mem_read, mem_2_reg, mem_write, alu_src, reg_write;
  logic [3:0]  alu_ctrl;
  logic [1:0]  wrt_back_src;
  logic [31:0] alu_results;
  logic        alu_zero;
  logic [31:0] r_dat, debug_data;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] mem_m [256];
  logic        mem_ready = 1'b0;

  alu_control_dmem dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .rs1(rs1), .rs2(rs2), .sign_ext(sign_ext), .init_done(init_done),
    .init_addr(init_addr), .init_dat(init_dat), .init_enb(init_enb),
    .debug_addr(debug_addr), .branch(branch), .imm_src(imm_src),
    .mem_read(mem_read), .mem_2_reg(mem_2_reg), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .alu_ctrl(alu_ctrl),
    .wrt_back_src(wrt_back_src), .alu_results(alu_results), .alu_zero(alu_zero),
    .r_dat(r_dat), .debug_data(debug_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       br;
    logic [2:0] imm;
    logic       mr, m2r, mw, asrc, rw;
    logic [3:0] op;
    logic [1:0] wb;
  } ctrl_t;

  logic [3:0] f3_map [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
  logic [6:0] opc_list [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                               7'b1100011, 7'b1101111, 7'b0110111};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference decode straight from the instruction table; branches decided
  // by comparing the register values directly.
  function automatic ctrl_t model_decode(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [31:0] a,
                                         input logic [31:0] b);
    ctrl_t c;
    c = '0;
    case (opc)
      7'b0110011: begin
        c.rw = 1'b1;
        c.op = (f3 == 3'd0 && f7[5]) ? 4'd1 : (f3 == 3'd5 && f7[5]) ? 4'd7 : f3_map[f3];
      end
      7'b0010011: begin
        c.asrc = 1'b1; c.rw = 1'b1;
        c.op = (f3 == 3'd5 && f7[5]) ? 4'd7 : f3_map[f3];
      end
      7'b0000011: begin
        c.asrc = 1'b1; c.mr = 1'b1; c.m2r = 1'b1; c.rw = 1'b1; c.wb = 2'b01;
      end
      7'b0100011: begin
        c.imm = 3'b001; c.asrc = 1'b1; c.mw = 1'b1;
      end
      7'b1100011: begin
        c.imm = 3'b010;
        case (f3)
          3'd0: begin c.op = 4'd1; c.br = (a == b); end
          3'd1: begin c.op = 4'd1; c.br = (a != b); end
          3'd4: begin c.op = 4'd8; c.br = ($signed(a) < $signed(b)); end
          3'd5: begin c.op = 4'd8; c.br = ($signed(a) >= $signed(b)); end
          3'd6: begin c.op = 4'd9; c.br = (a < b); end
          3'd7: begin c.op = 4'd9; c.br = (a >= b); end
          default: c.br = 1'b0;
        endcase
      end
      7'b1101111: begin
        c.imm = 3'b100; c.br = 1'b1; c.rw = 1'b1; c.wb = 2'b10;
      end
      7'b0110111: begin
        c.imm = 3'b011; c.asrc = 1'b1; c.rw = 1'b1; c.op = 4'd10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  // Sample outputs 1 time unit after the negedge drive, compare everything
  // against the model, then record the write the next posedge will perform.
  task automatic check_all(input string tag);
    ctrl_t       c, g;
    logic [31:0] b, res;
    #1;
    c   = model_decode(opcode, func3, func7, rs1, rs2);
    b   = c.asrc ? sign_ext : rs2;
    res = alu_ref(c.op, rs1, b);
    g   = rst ? c : '0;
    check({tag, ":ctrl"}, 32'({branch, imm_src, mem_read, mem_2_reg, mem_write,
                               alu_src, reg_write, alu_ctrl, wrt_back_src}), 32'(g));
    check({tag, ":alu"}, alu_results, res);
    check({tag, ":zero"}, {31'd0, alu_zero}, {31'd0, res == 32'd0});
    if (mem_ready || !g.mr) check({tag, ":rdat"}, r_dat, g.mr ? mem_m[res[9:2]] : 32'd0);
    if (mem_ready) check({tag, ":dbg"}, debug_data, mem_m[debug_addr[9:2]]);
    if (rst) begin
      if (init_done && g.mw) mem_m[res[9:2]] = rs2;
      else if (!init_done && init_enb) mem_m[init_addr[9:2]] = init_dat;
    end
  endtask

  initial begin
    rst = 1'b0; opcode = 7'd0; func3 = 3'd0; func7 = 7'd0;
    rs1 = 32'd0; rs2 = 32'd0; sign_ext = 32'd0; init_done = 1'b0;
    init_addr = 10'd0; init_dat = 32'd0; init_enb = 1'b0; debug_addr = 10'd0;

    // Reset: controls and r_dat zero, ALU still follows inputs.
    @(negedge clk); opcode = 7'b0000011; rs1 = 32'd4; sign_ext = 32'd8;
    check_all("rst_lw");
    check("rst_alu", alu_results, 32'd12);
    check("rst_rdat", r_dat, 32'd0);
    @(negedge clk); opcode = 7'b1101111;
    check_all("rst_jal");
    check("rst_branch", {31'd0, branch}, 32'd0);

    // Fill the whole BRAM through the init port.
    @(negedge clk); rst = 1'b1; opcode = 7'd0; init_enb = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      init_addr = 10'(i * 4); init_dat = $urandom;
      check_all("init");
    end
    @(negedge clk); mem_ready = 1'b1;
    init_addr = 10'h0; init_dat = 32'd3; check_all("init0");
    @(negedge clk); init_addr = 10'h4; init_dat = 32'd3; check_all("init4");
    @(negedge clk); init_addr = 10'h8; init_dat = 32'd5; check_all("init8");
    @(negedge clk); init_enb = 1'b0;
    debug_addr = 10'h0; #1; check("dbg0", debug_data, 32'd3);
    debug_addr = 10'h4; #1; check("dbg4", debug_data, 32'd3);
    debug_addr = 10'h8; #1; check("dbg8", debug_data, 32'd5);
    debug_addr = 10'h2; #1; check("dbg_alias", debug_data, 32'd3);

    // lw from address 8.
    @(negedge clk); init_done = 1'b1; opcode = 7'b0000011; func3 = 3'd2;
    rs1 = 32'd0; sign_ext = 32'd8;
    check_all("lw");
    check("lw_rdat", r_dat, 32'd5);
    check("lw_wb", {30'd0, wrt_back_src}, 32'd1);

    // sw 5 to 0xC, then an aborted store of 9 under reset.
    @(negedge clk); opcode = 7'b0100011; func3 = 3'd2; sign_ext = 32'hC; rs2 = 32'd5;
    check_all("sw");
    @(negedge clk); opcode = 7'd0; debug_addr = 10'hC;
    check_all("sw_rd");
    check("sw_dbg", debug_data, 32'd5);
    @(negedge clk); rst = 1'b0; opcode = 7'b0100011; rs2 = 32'd9;
    check_all("sw_rst");
    @(negedge clk); rst = 1'b1; opcode = 7'd0;
    check_all("sw_rst_rd");
    check("sw_rst_dbg", debug_data, 32'd5);

    // beq/bne.
    @(negedge clk); opcode = 7'b1100011; func3 = 3'd0; rs1 = 32'd3; rs2 = 32'd3;
    check_all("beq_eq"); check("beq_eq_br", {31'd0, branch}, 32'd1);
    @(negedge clk); func3 = 3'd1; check_all("bne_eq"); check("bne_eq_br", {31'd0, branch}, 32'd0);
    @(negedge clk); func3 = 3'd0; rs2 = 32'd5;
    check_all("beq_ne"); check("beq_ne_br", {31'd0, branch}, 32'd0);
    @(negedge clk); func3 = 3'd1;
    check_all("bne_ne"); check("bne_ne_br", {31'd0, branch}, 32'd1);
    check("b_imm", {29'd0, imm_src}, 32'd2);

    // ALU corner cases.
    @(negedge clk); opcode = 7'b0110011; func7 = 7'b0100000; func3 = 3'd0;
    rs1 = 32'd5; rs2 = 32'd3; check_all("sub"); check("sub_res", alu_results, 32'd2);
    @(negedge clk); func3 = 3'd5; rs1 = 32'h8000_0000; rs2 = 32'd4;
    check_all("sra"); check("sra_res", alu_results, 32'hF800_0000);
    @(negedge clk); func7 = 7'd0; func3 = 3'd3; rs1 = 32'hFFFF_FFFF; rs2 = 32'd1;
    check_all("sltu"); check("sltu_res", alu_results, 32'd0);
    @(negedge clk); func3 = 3'd2; check_all("slt"); check("slt_res", alu_results, 32'd1);

    // jal.
    @(negedge clk); opcode = 7'b1101111;
    check_all("jal");
    check("jal_ctl", {24'd0, branch, imm_src, wrt_back_src, reg_write, 1'b0},
          {24'd0, 1'b1, 3'b100, 2'b10, 1'b1, 1'b0});

    // Randomized vectors.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      opcode     = ($urandom_range(0, 7) == 0) ? 7'($urandom) : opc_list[$urandom_range(0, 6)];
      func3      = 3'($urandom);
      func7      = ($urandom_range(0, 1) == 0) ? 7'b0100000 : 7'($urandom);
      rs1        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1020)) : $urandom;
      rs2        = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      sign_ext   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
      rst        = ($urandom_range(0, 19) != 0);
      init_done  = ($urandom_range(0, 4) != 0);
      init_enb   = 1'($urandom);
      init_addr  = 10'($urandom);
      init_dat   = $urandom;
      debug_addr = 10'($urandom);
      check_all("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
